// File: rtl/fir_mac_filter.sv
// rtl/fir_mac_filter.sv - time-multiplexed FIR: one tap per clock, full-precision accumulate, round and saturate
module fir_mac_filter #(
   parameter int DATA_W    = 18,
   parameter int COEF_W    = 18,
   parameter int TAPS      = 64,
   parameter int ADDR_W    = 7,
   parameter int OUT_SHIFT = 17,
   parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] datain,
   input  logic                     endata,
   output logic signed [DATA_W-1:0] dataout,
   output logic                     dataout_valid,
   output logic                     busy,
   output logic                     overrun,
   output logic [ADDR_W-1:0]        coefaddress,
   input  logic signed [COEF_W-1:0] coefdata
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TAPS - 1);
   localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(TAPS);
   localparam int RSH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [ACC_W-1:0] ROUND_ADD = (OUT_SHIFT > 0) ? (ACC_W'(1) << RSH) : '0;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_FLUSH, S_OUT} state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         wptr_q, wptr_d;
   logic [ADDR_W-1:0]         k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [DATA_W-1:0]  x_q;
   logic signed [DATA_W-1:0]  dout_q, dout_d;
   logic                      valid_q, valid_d;
   logic                      ovr_q, ovr_d;
   logic                      wr_en;
   logic signed [DATA_W-1:0]  line_q [TAPS];

   logic [ADDR_W-1:0]         rd_idx;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   rnd, shf;
   logic signed [DATA_W-1:0]  sat_c;
   logic                      busy_c;

   // x[n-k] lives at (wptr-k) mod TAPS; wrap explicitly so TAPS need not be a power of two
   assign rd_idx = (k_q > wptr_q) ? (wptr_q + TAPS_A - k_q) : (wptr_q - k_q);
   assign prod   = PROD_W'(x_q) * PROD_W'(coefdata);
   assign busy_c = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_FLUSH);

   always_comb begin
      rnd = acc_q + ROUND_ADD;
      shf = rnd >>> OUT_SHIFT;
      if (shf > SAT_MAX)      sat_c = SAT_MAX[DATA_W-1:0];
      else if (shf < SAT_MIN) sat_c = SAT_MIN[DATA_W-1:0];
      else                    sat_c = shf[DATA_W-1:0];
   end

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      k_d     = k_q;
      acc_d   = acc_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      wr_en   = 1'b0;
      ovr_d   = endata && busy_c;
      case (state_q)
         S_IDLE, S_OUT: begin
            if (state_q == S_OUT) begin
               dout_d  = sat_c;
               valid_d = 1'b1;
            end
            if (endata) begin
               wr_en   = 1'b1;
               wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MAC;
         end
         S_MAC: begin
            // the product seen during k=0 is not yet aligned with a fetched coefficient
            if (k_q != '0) acc_d = acc_q + ACC_W'(prod);
            if (k_q == LAST) begin
               k_d     = '0;
               state_d = S_FLUSH;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_FLUSH: begin
            acc_d   = acc_q + ACC_W'(prod);
            state_d = S_OUT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         for (int i = 0; i < TAPS; i++) line_q[i] <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         x_q     <= line_q[rd_idx];
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         if (wr_en) line_q[wptr_d] <= datain;
      end
   end

   assign coefaddress   = k_q;
   assign dataout       = dout_q;
   assign dataout_valid = valid_q;
   assign busy          = busy_c;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb/tb_fir_mac_filter.sv - directed bench over four filter configurations sharing one sample stream
module tb_fir_mac_filter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic signed [17:0] din;
   logic               en;
   logic signed [17:0] dout  [4];
   logic               vld   [4];
   logic               bsy   [4];
   logic               ovr   [4];
   logic [6:0]         caddr [4];
   logic signed [17:0] cdat  [4];

   int nvec = 0;
   int nerr = 0;
   int vcnt [4];
   int vlat [4];
   logic signed [17:0] vval [4];
   int   ocnt;
   logic obusy;
   int   lat_tab [4] = '{7, 7, 5, 8};
   int   exp_w [11]  = '{1, 1, 3, 5, 10, 15, 20, 25, 30, 35, 40};
   int   imp_h [4]   = '{1, 2, 3, 4};

   // u0: TAPS=4 h={1,2,3,4}; u1: TAPS=4 shift 17 h=131071; u2: TAPS=2 shift 1 h={1,0}; u3: TAPS=5 h={1,-1,2,0,3}
   fir_mac_filter #(.TAPS(4), .OUT_SHIFT(0)) u0 (
      .clock(clk), .reset(rst_n), .datain(din), .endata(en), .dataout(dout[0]), .dataout_valid(vld[0]),
      .busy(bsy[0]), .overrun(ovr[0]), .coefaddress(caddr[0]), .coefdata(cdat[0]));
   fir_mac_filter #(.TAPS(4), .OUT_SHIFT(17)) u1 (
      .clock(clk), .reset(rst_n), .datain(din), .endata(en), .dataout(dout[1]), .dataout_valid(vld[1]),
      .busy(bsy[1]), .overrun(ovr[1]), .coefaddress(caddr[1]), .coefdata(cdat[1]));
   fir_mac_filter #(.TAPS(2), .OUT_SHIFT(1)) u2 (
      .clock(clk), .reset(rst_n), .datain(din), .endata(en), .dataout(dout[2]), .dataout_valid(vld[2]),
      .busy(bsy[2]), .overrun(ovr[2]), .coefaddress(caddr[2]), .coefdata(cdat[2]));
   fir_mac_filter #(.TAPS(5), .OUT_SHIFT(0)) u3 (
      .clock(clk), .reset(rst_n), .datain(din), .endata(en), .dataout(dout[3]), .dataout_valid(vld[3]),
      .busy(bsy[3]), .overrun(ovr[3]), .coefaddress(caddr[3]), .coefdata(cdat[3]));

   function automatic logic signed [17:0] rom(input int id, input logic [6:0] a);
      logic signed [17:0] r;
      r = 18'sd0;
      case (id)
         0: if (a < 7'd4) r = 18'(int'(a) + 1);
         1: r = 18'sd131071;
         2: r = (a == 7'd0) ? 18'sd1 : 18'sd0;
         default: begin
            case (a)
               7'd0: r = 18'sd1;
               7'd1: r = -18'sd1;
               7'd2: r = 18'sd2;
               7'd4: r = 18'sd3;
               default: r = 18'sd0;
            endcase
         end
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) cdat[i] <= rom(i, caddr[i]);
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulse endata once, then watch 12 cycles; optionally pulse a second endata in cycle ovr_at.
   task automatic apply(input logic signed [17:0] x, input int ovr_at, input logic signed [17:0] xd);
      for (int i = 0; i < 4; i++) begin
         vcnt[i] = 0;
         vlat[i] = -1;
         vval[i] = '0;
      end
      ocnt  = 0;
      obusy = 1'b0;
      din = x;
      en  = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (vld[i] === 1'b1) begin
               vcnt[i]++;
               vlat[i] = c;
               vval[i] = dout[i];
            end
         end
         if (ovr[0] === 1'b1) begin
            ocnt++;
            obusy = bsy[0];
         end
         if (c == ovr_at) begin
            din = xd;
            en  = 1'b1;
         end else begin
            en = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_out(input string tag, input int i, input int exp);
      chk({tag, " valid_count"}, vcnt[i], 1);
      chk({tag, " latency"}, vlat[i], lat_tab[i]);
      chk({tag, " dataout"}, vval[i], exp);
   endtask

   task automatic do_reset();
      en    = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      en    = 1'b0;
      din   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset dataout", dout[0], 0);
      chk("reset valid", vld[0], 0);
      chk("reset busy", bsy[0], 0);
      chk("reset overrun", ovr[0], 0);
      chk("reset coefaddress", caddr[0], 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply(18'sd1, -1, 18'sd0);
      chk_out("impulse y0", 0, 1);
      chk("impulse busy after", bsy[0], 0);
      for (int n = 1; n < 5; n++) begin
         apply(18'sd0, -1, 18'sd0);
         chk_out("impulse tail", 0, (n < 4) ? imp_h[n] : 0);
      end

      do_reset();
      for (int n = 0; n < 4; n++) begin
         apply(18'sd131071, -1, 18'sd0);
         if (n == 0) chk_out("possat first", 1, 131070);
         if (n == 3) chk_out("possat fourth", 1, 131071);
      end

      do_reset();
      for (int n = 0; n < 4; n++) begin
         apply(-18'sd131072, -1, 18'sd0);
         if (n == 0) chk_out("negsat first", 1, -131071);
         if (n == 3) chk_out("negsat fourth", 1, -131072);
      end

      do_reset();
      apply(18'sd3, -1, 18'sd0);
      chk_out("round +3", 2, 2);
      apply(-18'sd3, -1, 18'sd0);
      chk_out("round -3", 2, -1);
      apply(18'sd1, -1, 18'sd0);
      chk_out("round +1", 2, 1);

      do_reset();
      apply(18'sd5, 2, 18'sd100);
      chk("overrun pulses", ocnt, 1);
      chk("overrun busy", obusy, 1);
      chk_out("overrun y0", 0, 5);
      apply(18'sd0, -1, 18'sd0);
      chk("overrun quiet", ocnt, 0);
      chk_out("overrun y1", 0, 10);
      apply(18'sd0, -1, 18'sd0);
      chk_out("overrun y2", 0, 15);

      do_reset();
      for (int n = 1; n <= 11; n++) begin
         apply(18'(n), -1, 18'sd0);
         chk_out($sformatf("wrap y%0d", n), 3, exp_w[n-1]);
      end

      do_reset();
      apply(18'sd7, -1, 18'sd0);
      chk_out("prereset y", 0, 7);
      din = 18'sd8;
      en  = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("midpass coefaddress", caddr[0], 2);
      chk("midpass busy", bsy[0], 1);
      chk("midpass dataout held", dout[0], 7);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset dataout", dout[0], 0);
      chk("async reset busy", bsy[0], 0);
      chk("async reset coefaddress", caddr[0], 0);
      chk("async reset valid", vld[0], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (vld[0] === 1'b1) cnt++;
         @(posedge clk); #1;
      end
      chk("no partial result", cnt, 0);
      for (int n = 0; n < 4; n++) begin
         apply((n == 0) ? 18'sd1 : 18'sd0, -1, 18'sd0);
         chk_out("post reset impulse", 0, imp_h[n]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
